// File: rtl/signed_mul_pipe_if.sv
// rtl/signed_mul_pipe_if.sv - operand/result handshake bundle for signed_mul_pipe
interface signed_mul_pipe_if #(
   parameter int W     = 8,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic             is_signed;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [2*W-1:0]   c;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, a, b, is_signed, in_tag, out_ready,
      input  in_ready, out_valid, c, out_tag
   );

   modport slave (
      input  in_valid, a, b, is_signed, in_tag, out_ready,
      output in_ready, out_valid, c, out_tag
   );
endinterface

// File: rtl/signed_mul_pipe.sv
// rtl/signed_mul_pipe.sv - 3-stage sign/magnitude multiplier with valid/ready flow control
module signed_mul_pipe #(
   parameter int W     = 8,
   parameter int TAG_W = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   signed_mul_pipe_if.slave bus
);
   localparam logic [W:0]     ONE_M = (W+1)'(1);
   localparam logic [2*W-1:0] ONE_P = (2*W)'(1);

   logic             adv;
   logic             neg_a;
   logic             neg_b;
   logic [W:0]       ext_a;
   logic [W:0]       ext_b;
   logic [W:0]       mag_a_d;
   logic [W:0]       mag_b_d;
   logic             sign_d;
   logic [2*W-1:0]   prod_d;
   logic [2*W-1:0]   c_d;

   logic             s1_valid_q;
   logic [W:0]       s1_mag_a_q;
   logic [W:0]       s1_mag_b_q;
   logic             s1_sign_q;
   logic [TAG_W-1:0] s1_tag_q;

   logic             s2_valid_q;
   logic [2*W-1:0]   s2_prod_q;
   logic             s2_sign_q;
   logic [TAG_W-1:0] s2_tag_q;

   logic             s3_valid_q;
   logic [2*W-1:0]   s3_c_q;
   logic [TAG_W-1:0] s3_tag_q;

   always_comb begin
      adv     = !(s3_valid_q && !bus.out_ready);
      neg_a   = bus.is_signed && bus.a[W-1];
      neg_b   = bus.is_signed && bus.b[W-1];
      // W+1 bits so that -2^(W-1) negates to +2^(W-1) without wrapping
      ext_a   = {neg_a, bus.a};
      ext_b   = {neg_b, bus.b};
      mag_a_d = neg_a ? (~ext_a + ONE_M) : ext_a;
      mag_b_d = neg_b ? (~ext_b + ONE_M) : ext_b;
      sign_d  = bus.is_signed && (bus.a[W-1] ^ bus.b[W-1]);
      // magnitudes never exceed 2^W-1, so the 2W-bit product is exact
      prod_d  = {{(W-1){1'b0}}, s1_mag_a_q} * {{(W-1){1'b0}}, s1_mag_b_q};
      c_d     = s2_sign_q ? (~s2_prod_q + ONE_P) : s2_prod_q;
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = s3_valid_q;
   assign bus.c         = s3_c_q;
   assign bus.out_tag   = s3_tag_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_mag_a_q <= '0;
         s1_mag_b_q <= '0;
         s1_sign_q  <= 1'b0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_prod_q  <= '0;
         s2_sign_q  <= 1'b0;
         s2_tag_q   <= '0;
         s3_valid_q <= 1'b0;
         s3_c_q     <= '0;
         s3_tag_q   <= '0;
      end else if (adv) begin
         s1_valid_q <= bus.in_valid;
         s1_mag_a_q <= mag_a_d;
         s1_mag_b_q <= mag_b_d;
         s1_sign_q  <= sign_d;
         s1_tag_q   <= bus.in_tag;
         s2_valid_q <= s1_valid_q;
         s2_prod_q  <= prod_d;
         s2_sign_q  <= s1_sign_q;
         s2_tag_q   <= s1_tag_q;
         s3_valid_q <= s2_valid_q;
         s3_c_q     <= c_d;
         s3_tag_q   <= s2_tag_q;
      end
   end
endmodule
